// File: rtl/armaria_fetch_pkg.sv
// Shared types and default widths for the instruction fetch unit.
package armaria_fetch_pkg;

    localparam int DEFAULT_ADDR_WIDTH       = 14;
    localparam int DEFAULT_INSTRUCTION_SIZE = 16;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        S_START,
        S_RUN,
        S_FLUSH
    } fetch_state_t;

    // One prefetch buffer entry at the default widths.
    typedef struct packed {
        logic [DEFAULT_INSTRUCTION_SIZE-1:0] instruction;
        logic [DEFAULT_ADDR_WIDTH-1:0]       pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous prefetch FIFO holding instruction/pc entries.
// Flush empties the buffer and resets both pointers in one cycle.
// When empty, head holds the last entry presented (zero after reset).
module fetch_fifo
    import armaria_fetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       push,
    input  entry_t                     push_entry,
    input  logic                       pop,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     count,
    output entry_t                     head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    entry_t          storage [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    entry_t          head_hold;

    // Write the storage array; flush drops any same-cycle push.
    // NOTE: the data array has no reset; only pointers and count must be
    // defined, and leaving the array unreset keeps it a plain RAM.
    always_ff @(posedge clock) begin
        if (push && !flush) begin
            storage[wr_ptr] <= push_entry;
        end
    end

    // Pointer and occupancy bookkeeping.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Remember the most recent head so the outputs hold while empty.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_hold <= '0;
        end else if (count != '0) begin
            head_hold <= storage[rd_ptr];
        end
    end

    assign head = (count != '0) ? storage[rd_ptr] : head_hold;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: issues word addresses to a one-cycle-latency
// instruction memory, buffers returned instructions with their pc in a
// prefetch FIFO and hands them to decode over valid/ready. A branch flushes
// the buffer, discards any in-flight read and redirects fetch.
// Optional build macro FETCH_STATS_EN adds saturating issue/flush counters.
module instruction_fetch_unit
    import armaria_fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH       = DEFAULT_ADDR_WIDTH,
    parameter int                    INSTRUCTION_SIZE = DEFAULT_INSTRUCTION_SIZE,
    parameter int                    FIFO_DEPTH       = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC         = '0
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        branch_valid,
    input  logic [ADDR_WIDTH-1:0]       branch_target,
    output logic [ADDR_WIDTH-1:0]       instruction_address,
    output logic                        fetch_request,
    input  logic [INSTRUCTION_SIZE-1:0] instruction_in,
    output logic                        fetch_valid,
    output logic [INSTRUCTION_SIZE-1:0] fetch_instruction,
    output logic [ADDR_WIDTH-1:0]       fetch_pc,
    input  logic                        fetch_ready
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]                 issued_count,
    output logic [31:0]                 flush_count
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [INSTRUCTION_SIZE-1:0] instruction;
        logic [ADDR_WIDTH-1:0]       pc;
    } entry_t;

    fetch_state_t           state;
    fetch_state_t           state_next;
    logic [ADDR_WIDTH-1:0]  pc;
    logic                   pending;
    logic [ADDR_WIDTH-1:0]  pending_pc;
    logic [CW-1:0]          count;
    entry_t                 head;
    entry_t                 push_entry;
    logic                   issue;
    logic                   pop;
    logic                   push;
    logic                   credit_ok;
    logic [CW:0]            in_use;
    logic [CW:0]            limit;

    // A pop in the branch cycle is ignored; the buffer is being flushed.
    assign pop  = fetch_valid && fetch_ready && !branch_valid;
    // The read issued last cycle lands now unless a branch discards it.
    assign push = pending && !branch_valid;

    // Credit check: entries held plus the read in flight, less this cycle's
    // pop, must leave room. Written as in_use < depth + pop to avoid underflow.
    assign in_use    = {1'b0, count} + (CW + 1)'(pending);
    assign limit     = (CW + 1)'(FIFO_DEPTH) + (CW + 1)'(pop);
    assign credit_ok = in_use < limit;

    // Next-state and issue decision; a branch overrides everything.
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        if (branch_valid) begin
            state_next = S_FLUSH;
        end else begin
            case (state)
                S_START: state_next = S_RUN;
                S_RUN: begin
                    state_next = S_RUN;
                    issue      = credit_ok;
                end
                S_FLUSH: state_next = S_RUN;
                default: state_next = S_START;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_START;
        end else begin
            state <= state_next;
        end
    end

    // Fetch pc: redirect on branch, advance one word per issued request.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc <= RESET_PC;
        end else if (branch_valid) begin
            pc <= branch_target;
        end else if (issue) begin
            pc <= pc + ADDR_WIDTH'(1);
        end
    end

    // Track the single outstanding memory read and the pc it belongs to.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending    <= 1'b0;
            pending_pc <= '0;
        end else if (branch_valid) begin
            pending    <= 1'b0;
        end else begin
            pending <= issue;
            if (issue) begin
                pending_pc <= pc;
            end
        end
    end

    assign push_entry = '{instruction: instruction_in, pc: pending_pc};

    fetch_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (branch_valid),
        .count      (count),
        .head       (head)
    );

    assign instruction_address = pc;
    assign fetch_request       = issue;
    assign fetch_valid         = (count != '0);
    assign fetch_instruction   = head.instruction;
    assign fetch_pc            = head.pc;

`ifdef FETCH_STATS_EN
    // Saturating count of issued requests.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            issued_count <= '0;
        end else if (issue && (issued_count != 32'hFFFF_FFFF)) begin
            issued_count <= issued_count + 32'd1;
        end
    end

    // Saturating count of branch redirects.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            flush_count <= '0;
        end else if (branch_valid && (flush_count != 32'hFFFF_FFFF)) begin
            flush_count <= flush_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit. Memory word k holds 0x1000+k and answers
// one cycle after the address. Stimulus pushes the expected (pc, instruction)
// stream into a queue; a monitor pops and compares on every decode handshake.
module tb_instruction_fetch_unit;

    localparam int AW = 14;
    localparam int IW = 16;

    typedef struct {
        logic [AW-1:0] pc;
        logic [IW-1:0] instr;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset_n = 1'b1;
    logic          branch_valid = 1'b0;
    logic [AW-1:0] branch_target = '0;
    logic [AW-1:0] instruction_address;
    logic          fetch_request;
    logic [IW-1:0] instruction_in;
    logic          fetch_valid;
    logic [IW-1:0] fetch_instruction;
    logic [AW-1:0] fetch_pc;
    logic          fetch_ready = 1'b0;
`ifdef FETCH_STATS_EN
    logic [31:0]   issued_count;
    logic [31:0]   flush_count;
`endif

    logic [AW-1:0] mem_addr_q;
    exp_t          exp_q[$];
    int            tests  = 0;
    int            failed = 0;
    int            pops   = 0;
    int            req_seen = 0;

    instruction_fetch_unit dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .branch_valid        (branch_valid),
        .branch_target       (branch_target),
        .instruction_address (instruction_address),
        .fetch_request       (fetch_request),
        .instruction_in      (instruction_in),
        .fetch_valid         (fetch_valid),
        .fetch_instruction   (fetch_instruction),
        .fetch_pc            (fetch_pc),
        .fetch_ready         (fetch_ready)
`ifdef FETCH_STATS_EN
        ,
        .issued_count        (issued_count),
        .flush_count         (flush_count)
`endif
    );

    always #5 clock = ~clock;

    // Synchronous-read memory: word k holds 0x1000 + k.
    always @(posedge clock) mem_addr_q <= instruction_address;
    assign instruction_in = IW'(16'h1000 + {2'b00, mem_addr_q});

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic push_expected(input logic [AW-1:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.pc    = AW'(start + AW'(i));
            e.instr = IW'(16'h1000 + {2'b00, e.pc});
            exp_q.push_back(e);
        end
    endtask

    // Monitor: compare every accepted head against the scoreboard.
    always @(negedge clock) begin
        if (!reset_n) begin
            req_seen = 0;
        end else begin
            if (fetch_request) req_seen++;
            if (fetch_valid && fetch_ready && !branch_valid) begin
                pops++;
                if (exp_q.size() == 0) begin
                    tests++;
                    failed++;
                    $display("FAIL unexpected_pop: got pc 0x%0h, expected no output", fetch_pc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("head_pc", 32'(fetch_pc), 32'(e.pc));
                    check("head_instr", 32'(fetch_instruction), 32'(e.instr));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        int nreq;

        // Reset values.
        #1 reset_n = 1'b0;
        fetch_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("rst_fetch_request", 32'(fetch_request), 32'd0);
        check("rst_fetch_valid", 32'(fetch_valid), 32'd0);
        check("rst_fetch_instruction", 32'(fetch_instruction), 32'd0);
        check("rst_fetch_pc", 32'(fetch_pc), 32'd0);
        check("rst_instruction_address", 32'(instruction_address), 32'd0);

        // Phase A: free-running fetch from reset.
        @(posedge clock);
        #2 reset_n = 1'b1;                  // cycle 0 (S_START)
        base = pops;
        push_expected(14'h0000, 6);
        @(negedge clock);
        check("a_c0_request", 32'(fetch_request), 32'd0);
        @(negedge clock);
        check("a_c1_request", 32'(fetch_request), 32'd1);
        check("a_c1_address", 32'(instruction_address), 32'h0);
        check("a_c1_valid", 32'(fetch_valid), 32'd0);
        @(negedge clock);
        check("a_c2_address", 32'(instruction_address), 32'h1);
        check("a_c2_valid", 32'(fetch_valid), 32'd0);
        @(negedge clock);
        check("a_c3_valid", 32'(fetch_valid), 32'd1);
        check("a_c3_pc", 32'(fetch_pc), 32'h0);
        repeat (5) @(negedge clock);        // cycle 8
        @(posedge clock);
        #1 fetch_ready = 1'b0;
        check("a_pop_count", 32'(pops - base), 32'd6);
        check("a_queue_drained", 32'(exp_q.size()), 32'd0);

        // Phase B: asynchronous reset mid-stream, then stall with ready low.
        #2 reset_n = 1'b0;
        #1;
        check("b_rst_valid", 32'(fetch_valid), 32'd0);
        check("b_rst_request", 32'(fetch_request), 32'd0);
        check("b_rst_pc", 32'(fetch_pc), 32'd0);
        check("b_rst_instr", 32'(fetch_instruction), 32'd0);
        check("b_rst_address", 32'(instruction_address), 32'd0);
        exp_q.delete();
        @(posedge clock);
        #2 reset_n = 1'b1;                  // cycle 0
        nreq = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            if (fetch_request) begin
                check("b_stall_address", 32'(instruction_address), 32'(nreq));
                nreq++;
            end
        end
        check("b_stall_requests", 32'(nreq), 32'd4);
        check("b_stall_valid", 32'(fetch_valid), 32'd1);
        check("b_stall_head_pc", 32'(fetch_pc), 32'h0);
        check("b_stall_head_instr", 32'(fetch_instruction), 32'h1000);
        base = pops;
        push_expected(14'h0000, 8);
        @(posedge clock);
        #1 fetch_ready = 1'b1;              // cycle R
        repeat (8) @(negedge clock);        // R .. R+7
        @(posedge clock);
        #1;                                 // cycle R+8: 3 held, 1 in flight
        check("b_pop_count", 32'(pops - base), 32'd8);
        check("b_queue_drained", 32'(exp_q.size()), 32'd0);

        // Phase C: branch with a full-ish buffer and a read in flight.
        branch_valid  = 1'b1;
        branch_target = 14'h0200;
        base = pops;
        push_expected(14'h0200, 4);
        @(posedge clock);
        #1 branch_valid = 1'b0;             // R+9 (flush bubble)
        @(negedge clock);
        check("c_flush_valid", 32'(fetch_valid), 32'd0);
        check("c_flush_request", 32'(fetch_request), 32'd0);
        @(negedge clock);                   // R+10
        check("c_target_request", 32'(fetch_request), 32'd1);
        check("c_target_address", 32'(instruction_address), 32'h0200);
        check("c_r10_valid", 32'(fetch_valid), 32'd0);
        @(negedge clock);                   // R+11
        check("c_r11_valid", 32'(fetch_valid), 32'd0);
        @(negedge clock);                   // R+12: three cycles after the bubble
        check("c_target_valid", 32'(fetch_valid), 32'd1);
        check("c_target_pc", 32'(fetch_pc), 32'h0200);
        repeat (3) @(negedge clock);        // R+15
        @(posedge clock);
        #1 fetch_ready = 1'b0;              // R+16
        check("c_pop_count", 32'(pops - base), 32'd4);
        check("c_queue_drained", 32'(exp_q.size()), 32'd0);

        // Phase D: back-to-back branches, last wins, then address wrap.
        branch_valid  = 1'b1;
        branch_target = 14'h0100;
        base = pops;
        push_expected(14'h3FFE, 4);
        @(posedge clock);
        #1 branch_target = 14'h3FFE;        // R+17, second branch
        @(posedge clock);
        #1 begin                            // R+18
            branch_valid = 1'b0;
            fetch_ready  = 1'b1;
        end
        @(negedge clock);
        check("d_flush_valid", 32'(fetch_valid), 32'd0);
        check("d_flush_request", 32'(fetch_request), 32'd0);
        @(negedge clock);                   // R+19
        check("d_addr_3ffe", 32'(instruction_address), 32'h3FFE);
        @(negedge clock);                   // R+20
        check("d_addr_3fff", 32'(instruction_address), 32'h3FFF);
        check("d_r20_valid", 32'(fetch_valid), 32'd0);
        @(negedge clock);                   // R+21
        check("d_addr_wrap", 32'(instruction_address), 32'h0000);
        check("d_first_pc", 32'(fetch_pc), 32'h3FFE);
        repeat (3) @(negedge clock);        // R+24
        @(posedge clock);
        #1 fetch_ready = 1'b0;
        check("d_pop_count", 32'(pops - base), 32'd4);
        check("d_queue_drained", 32'(exp_q.size()), 32'd0);

`ifdef FETCH_STATS_EN
        check("stats_flush_count", flush_count, 32'd3);
        check("stats_issued_count", issued_count, 32'(req_seen));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
